// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised multi-port register array.
package rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_DW  = 32;
  localparam int RF_AW  = 5;
  localparam int RF_NRD = 2;

  // Even parity over up to 64 data bits; callers zero-extend narrower words.
  function automatic logic rf_parity(input logic [63:0] i_d);
    return ^i_d;
  endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset clear sequencer: walks every bank entry once, then parks in RUN.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic          i_clock,
  input  logic          i_rst,
  output logic          o_init_busy,
  output logic          o_clr_we,
  output logic [AW-1:0] o_clr_addr,
  output rf_state_e     o_state
);

  rf_state_e     r_state;
  rf_state_e     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_nxt;

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_we    = 1'b0;
    case (r_state)
      RF_INIT: begin
        o_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        // Leave INIT on the same edge that clears the last entry.
        if (r_cnt == {AW{1'b1}}) w_state_nxt = RF_RUN;
      end
      RF_RUN:  w_state_nxt = RF_RUN;
      default: w_state_nxt = RF_INIT;
    endcase
  end

  assign o_init_busy = (r_state == RF_INIT);
  assign o_clr_addr  = r_cnt;
  assign o_state     = r_state;

endmodule

// File: rtl/rf_array_mp.sv
// Multi-read-port register array with registered write/read-address, forwarding
// and a post-reset clear; optional per-entry parity under RF_PARITY_EN.
module rf_array_mp
  import rf_pkg::*;
#(
  parameter int DW       = RF_DW,
  parameter int AW       = RF_AW,
  parameter int NRD      = RF_NRD,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              pause,
  input  logic              rd_clk_cls,
  input  logic              wren,
  input  logic [AW-1:0]     wraddress,
  input  logic [DW-1:0]     data,
  input  logic [NRD*AW-1:0] rdaddress,
  output logic [NRD*DW-1:0] q,
  output logic              init_busy,
  output logic [NRD-1:0]    par_err
);

  localparam int DEPTH = 1 << AW;
`ifdef RF_PARITY_EN
  localparam int BW = DW + 1;
`else
  localparam int BW = DW;
`endif

  logic [BW-1:0] r_bank [DEPTH];
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_wraddress;
  logic          r_wren;
  logic [AW-1:0] r_rdaddress [NRD];

  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;
  rf_state_e     w_state;
  logic          w_run;
  logic          w_wr_drop;
  logic [BW-1:0] w_wr_entry;

  rf_init_seq #(.AW(AW)) u_init_seq (
    .i_clock     (clock),
    .i_rst       (rst),
    .o_init_busy (init_busy),
    .o_clr_we    (w_clr_we),
    .o_clr_addr  (w_clr_addr),
    .o_state     (w_state)
  );

  assign w_run     = (w_state == RF_RUN);
  assign w_wr_drop = (ZERO_REG != 0) && (wraddress == '0);

`ifdef RF_PARITY_EN
  assign w_wr_entry = {rf_parity(64'(r_data)), r_data};
`else
  assign w_wr_entry = r_data;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_data      <= '0;
      r_wraddress <= '0;
      r_wren      <= 1'b0;
    end else begin
      if (!pause) begin
        r_data      <= data;
        r_wraddress <= wraddress;
      end
      if (!w_run)      r_wren <= 1'b0;
      else if (!pause) r_wren <= wren && !w_wr_drop;
    end
  end

  // Held writes (pause=1) re-write the same value each edge, which is benign.
  always_ff @(posedge clock) begin
    if (w_clr_we)    r_bank[w_clr_addr]  <= '0;
    else if (r_wren) r_bank[r_wraddress] <= w_wr_entry;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NRD; k++) r_rdaddress[k] <= '0;
    end else if (!pause && !rd_clk_cls) begin
      for (int k = 0; k < NRD; k++) r_rdaddress[k] <= rdaddress[k*AW +: AW];
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    logic [BW-1:0] w_entry;
    logic          w_zero;
    logic          w_fwd;

    assign w_entry = r_bank[r_rdaddress[k]];
    assign w_zero  = (ZERO_REG != 0) && (r_rdaddress[k] == '0);
    assign w_fwd   = r_wren && (r_wraddress == r_rdaddress[k]);

    assign q[k*DW +: DW] = !w_run ? '0 :
                           w_zero ? '0 :
                           w_fwd  ? r_data : w_entry[DW-1:0];

`ifdef RF_PARITY_EN
    assign par_err[k] = w_run && !w_zero && !w_fwd &&
                        (rf_parity(64'(w_entry[DW-1:0])) != w_entry[DW]);
`else
    assign par_err[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rf_array_mp.sv
// Directed scoreboard bench for rf_array_mp (NRD=4, DW=32, AW=5, ZERO_REG=1).
module tb_rf_array_mp;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;
  localparam int W   = 1 + NRD + NRD*DW;

  logic              clock;
  logic              rst;
  logic              pause;
  logic              rd_clk_cls;
  logic              wren;
  logic [AW-1:0]     wraddress;
  logic [DW-1:0]     data;
  logic [NRD*AW-1:0] rdaddress;
  logic [NRD*DW-1:0] q;
  logic              init_busy;
  logic [NRD-1:0]    par_err;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec;
  int           n_err;

  rf_array_mp #(.DW(DW), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clock      (clock),
    .rst        (rst),
    .pause      (pause),
    .rd_clk_cls (rd_clk_cls),
    .wren       (wren),
    .wraddress  (wraddress),
    .data       (data),
    .rdaddress  (rdaddress),
    .q          (q),
    .init_busy  (init_busy),
    .par_err    (par_err)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Monitor: outputs are observed on the falling edge, away from the active edge.
  always @(negedge clock) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    string        nm;
    act = {init_busy, par_err, q};
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      nm  = name_q.pop_front();
      n_vec++;
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got busy=%b par=%b q=%h, want busy=%b par=%b q=%h",
                 nm, act[W-1], act[W-2 -: NRD], act[NRD*DW-1:0],
                 exp[W-1], exp[W-2 -: NRD], exp[NRD*DW-1:0]);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string nm, input logic busy, input logic [NRD-1:0] pe,
                            input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                            input logic [DW-1:0] a2, input logic [DW-1:0] a3);
    exp_q.push_back({busy, pe, a3, a2, a1, a0});
    name_q.push_back(nm);
  endtask

  task automatic check_reset_state(input string nm);
    n_vec++;
    if (init_busy !== 1'b1 || par_err !== '0 || q !== '0) begin
      n_err++;
      $display("FAIL %s: reset state busy=%b par=%b q=%h", nm, init_busy, par_err, q);
    end
  endtask

  task automatic wait_busy_low(input string nm, input int max_cycles);
    int n;
    n = 0;
    while (init_busy !== 1'b0 && n < max_cycles) begin
      tick();
      n++;
    end
    n_vec++;
    if (init_busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s: init_busy still high after %0d cycles", nm, max_cycles);
    end
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rdaddress = {a3, a2, a1, a0};
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wren = 1'b1; wraddress = a; data = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic run_init(input string nm);
    for (int i = 0; i < 32; i++) begin
      expect_out(nm, 1'b1, '0, '0, '0, '0, '0);
      tick();
    end
    expect_out({nm, "_done"}, 1'b0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; pause = 1'b0; rd_clk_cls = 1'b0; wren = 1'b0;
    wraddress = '0; data = '0; rdaddress = '0;
    tick(); tick();
    check_reset_state("reset_state");
    expect_out("reset", 1'b1, '0, '0, '0, '0, '0);
    tick();
    rst = 1'b0;
    run_init("init");
    wait_busy_low("init_wait", 4);
    tick();

    // Basic write, read two edges later from the bank
    write(5, 32'h12345678);
    set_rd(5, 0, 0, 0);
    tick();
    expect_out("basic_r5", 1'b0, '0, 32'h12345678, '0, '0, '0);
    tick();

    // Forwarding: write and read R7 captured on the same edge
    wren = 1'b1; wraddress = 7; data = 32'hA5A5A5A5;
    set_rd(0, 7, 0, 0);
    tick();
    wren = 1'b0;
    expect_out("fwd_r7", 1'b0, '0, '0, 32'hA5A5A5A5, '0, '0);
    tick();
    expect_out("bank_r7", 1'b0, '0, '0, 32'hA5A5A5A5, '0, '0);
    tick();

    // Zero register: write to R0 dropped, even with a same-edge read
    wren = 1'b1; wraddress = 0; data = 32'hFFFFFFFF;
    set_rd(0, 0, 0, 0);
    tick();
    wren = 1'b0;
    expect_out("zero_fwd", 1'b0, '0, '0, '0, '0, '0);
    tick();
    expect_out("zero_bank", 1'b0, '0, '0, '0, '0, '0);
    write(3, 32'h11);
    set_rd(3, 3, 3, 3);
    tick();
    expect_out("r3_all", 1'b0, '0, 32'h11, 32'h11, 32'h11, 32'h11);
    tick();

    // Pause freezes write capture and read addresses
    pause = 1'b1; wren = 1'b1; wraddress = 3; data = 32'h22;
    set_rd(5, 5, 5, 5);
    tick();
    expect_out("pause_1", 1'b0, '0, 32'h11, 32'h11, 32'h11, 32'h11);
    tick();
    expect_out("pause_2", 1'b0, '0, 32'h11, 32'h11, 32'h11, 32'h11);
    pause = 1'b0; wren = 1'b0;
    set_rd(3, 3, 3, 3);
    tick(); tick();
    expect_out("pause_nowr", 1'b0, '0, 32'h11, 32'h11, 32'h11, 32'h11);
    tick();

    // rd_clk_cls holds read addresses while the write proceeds
    rd_clk_cls = 1'b1;
    set_rd(5, 5, 5, 5);
    write(3, 32'h33);
    expect_out("cls_fwd", 1'b0, '0, 32'h33, 32'h33, 32'h33, 32'h33);
    tick();
    expect_out("cls_bank", 1'b0, '0, 32'h33, 32'h33, 32'h33, 32'h33);
    rd_clk_cls = 1'b0;
    tick();
    expect_out("cls_rel", 1'b0, '0, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    set_rd(5, 7, 3, 0);
    tick();
    expect_out("mixed", 1'b0, '0, 32'h12345678, 32'hA5A5A5A5, 32'h33, '0);
    tick();

`ifdef RF_PARITY_EN
    write(9, 32'h0000_0F01);
    set_rd(9, 0, 0, 0);
    tick();
    expect_out("par_ok", 1'b0, '0, 32'h0000_0F01, '0, '0, '0);
    tick();
    dut.r_bank[9][0] = ~dut.r_bank[9][0];
    #1;
    expect_out("par_err", 1'b0, 4'b0001, 32'h0000_0F00, '0, '0, '0);
    tick();
    write(9, 32'h0000_0003);
    expect_out("par_fwd", 1'b0, '0, 32'h0000_0003, '0, '0, '0);
    tick();
`endif

    // Fill every entry, then reset and confirm the sequencer clears them all
    for (int a = 1; a < 32; a++) write(AW'(a), 32'hDEADBEEF ^ 32'(a));
    tick();
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), 0, 0, 0);
      tick();
      expect_out("fill", 1'b0, '0, (a == 0) ? 32'h0 : (32'hDEADBEEF ^ 32'(a)), '0, '0, '0);
    end
    tick();
    rst = 1'b1;
    tick();
    expect_out("rst_q0", 1'b1, '0, '0, '0, '0, '0);
    rst = 1'b0;
    // Reset again partway through INIT; the full clear must restart
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    check_reset_state("reset_mid_init");
    rst = 1'b0;
    run_init("reinit");
    wait_busy_low("reinit_wait", 4);
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a), 0, 0);
      tick();
      expect_out("cleared", 1'b0, '0, '0, '0, '0, '0);
    end

    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
